// File: rtl/program_loader_if.sv
// Byte-stream handshake between the host/UART source and the program loader.
interface program_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/program_loader.sv
// Boot-time instruction-memory loader: packs streamed bytes big-endian into
// 32-bit words, writes them from address 0 upward and stalls the CPU meanwhile.
module program_loader #(
  parameter int MEM_SIZE   = 150,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic                  abort,
  program_loader_if.slave       stream,
  input  logic [ADDR_WIDTH-1:0] cpu_pc,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [1:0]            byte_cnt;
  logic [23:0]           word_buf;
  logic                  byte_ready;
  logic                  accept;
  logic                  len_bad;
  logic                  last_word;

  assign byte_ready        = (state == RECV);
  assign stream.byte_ready = byte_ready;
  assign accept            = stream.byte_valid && byte_ready;
  assign len_bad           = (load_len == '0) || (load_len > MAX_LEN);
  assign last_word         = (wr_ptr == len_q - ONE);

  // The loader owns the address port only while it is receiving or writing.
  assign instr_addr = (state == RECV || state == WRITE) ? wr_ptr : cpu_pc;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = len_bad ? ERR : RECV;
      RECV: begin
        if (abort)                             state_next = ERR;
        else if (accept && byte_cnt == 2'd3)   state_next = WRITE;
      end
      WRITE: begin
        if (abort)          state_next = ERR;
        else if (last_word) state_next = DONE;
        else                state_next = RECV;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_q     <= '0;
      wr_ptr    <= '0;
      byte_cnt  <= 2'd0;
      word_buf  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we   <= (state_next == WRITE);
      cpu_hold <= (state_next == RECV) || (state_next == WRITE) || (state_next == DONE);
      done     <= (state_next == DONE);
      error    <= (state_next == ERR);
      case (state)
        IDLE: begin
          if (start && !len_bad) begin
            len_q    <= load_len;
            wr_ptr   <= '0;
            byte_cnt <= 2'd0;
          end
        end
        RECV: begin
          if (abort) begin
            byte_cnt <= 2'd0;
          end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_buf <= {word_buf[15:0], stream.byte_in};
            if (byte_cnt == 2'd3) mem_wdata <= {word_buf, stream.byte_in};
          end
        end
        WRITE: begin
          if (!abort && !last_word) wr_ptr <= wr_ptr + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader with a write-capturing memory model.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] load_len;
  logic        abort;
  logic [19:0] cpu_pc;
  logic [19:0] instr_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  program_loader_if bif ();

  program_loader #(.MEM_SIZE(150), .ADDR_WIDTH(20)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .load_len   (load_len),
    .abort      (abort),
    .stream     (bif.slave),
    .cpu_pc     (cpu_pc),
    .instr_addr (instr_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] BLANK = 32'hEEEE_EEEE;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc_cnt  = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          hold_cnt = 0;
  int          rdy_viol = 0;
  int          done_cyc = 0;
  int          err_cyc  = 0;
  int          start_cyc = 0;
  logic [19:0] last_addr = '0;
  logic [31:0] model [0:255];
  logic [7:0]  stream_bytes [0:1023];

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clock) begin
    if (mem_we) begin
      model[instr_addr[7:0]] = mem_wdata;
      wr_cnt++;
      last_addr = instr_addr;
      if (bif.byte_ready) rdy_viol++;
    end
    if (done)  begin done_cnt++; done_cyc = cyc_cnt; end
    if (error) begin err_cnt++;  err_cyc  = cyc_cnt; end
    if (cpu_hold) hold_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = BLANK;
  endtask

  // Called just after a rising edge; start is sampled by the following edge.
  task automatic do_start(input logic [19:0] len);
    start     = 1'b1;
    load_len  = len;
    start_cyc = cyc_cnt;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_bytes(input int first, input int n, input bit toggle);
    int idx;
    int k;
    bit acc;
    idx = 0;
    k   = 0;
    while (idx < n && k < 4000) begin
      bif.byte_valid = toggle ? (k % 2 == 0) : 1'b1;
      bif.byte_in    = stream_bytes[first + idx];
      @(negedge clock);
      acc = bif.byte_valid && bif.byte_ready;
      @(posedge clock); #1;
      if (acc) idx++;
      k++;
    end
    bif.byte_valid = 1'b0;
    chk("feeder_budget", idx, n);
  endtask

  task automatic wait_done(input int snap);
    for (int i = 0; i < 300 && done_cnt == snap; i++) @(negedge clock);
    @(posedge clock); #1;
  endtask

  task automatic wait_err(input int snap);
    for (int i = 0; i < 50 && err_cnt == snap; i++) @(negedge clock);
    @(posedge clock); #1;
  endtask

  int          w0, d0, e0;
  logic [31:0] exp_w;

  initial begin
    reset = 1'b1; start = 1'b0; load_len = '0; abort = 1'b0;
    cpu_pc = 20'h0ABCD; bif.byte_in = '0; bif.byte_valid = 1'b0;
    clear_model();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_byte_ready", bif.byte_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done_err", {done, error}, 0);
    chk("rst_addr", instr_addr, cpu_pc);
    @(posedge clock); #1;

    // Two words, back-to-back bytes
    stream_bytes[0] = 8'h20; stream_bytes[1] = 8'h00; stream_bytes[2] = 8'h00; stream_bytes[3] = 8'h42;
    stream_bytes[4] = 8'h30; stream_bytes[5] = 8'h1D; stream_bytes[6] = 8'h00; stream_bytes[7] = 8'h00;
    w0 = wr_cnt; d0 = done_cnt; hold_cnt = 0;
    do_start(20'd2);
    send_bytes(0, 8, 1'b0);
    wait_done(d0);
    chk("b2b_writes", wr_cnt - w0, 2);
    chk("b2b_word0", model[0], 32'h2000_0042);
    chk("b2b_word1", model[1], 32'h301D_0000);
    chk("b2b_untouched", model[2], BLANK);
    chk("b2b_done_cnt", done_cnt - d0, 1);
    chk("b2b_done_lat", done_cyc - start_cyc, 11);
    chk("b2b_hold_cycles", hold_cnt, 11);
    chk("b2b_idle_hold", cpu_hold, 0);
    chk("b2b_idle_addr", instr_addr, cpu_pc);

    // Same load with byte_valid toggling
    clear_model();
    w0 = wr_cnt; d0 = done_cnt; rdy_viol = 0;
    do_start(20'd2);
    send_bytes(0, 8, 1'b1);
    wait_done(d0);
    chk("tog_writes", wr_cnt - w0, 2);
    chk("tog_word0", model[0], 32'h2000_0042);
    chk("tog_word1", model[1], 32'h301D_0000);
    chk("tog_ready_in_write", rdy_viol, 0);
    chk("tog_done_cnt", done_cnt - d0, 1);

    // Bad lengths
    w0 = wr_cnt; e0 = err_cnt; hold_cnt = 0;
    do_start(20'd0);
    wait_err(e0);
    chk("len0_err", err_cnt - e0, 1);
    chk("len0_err_lat", err_cyc - start_cyc, 1);
    e0 = err_cnt;
    do_start(20'd151);
    wait_err(e0);
    chk("len151_err", err_cnt - e0, 1);
    chk("len151_err_lat", err_cyc - start_cyc, 1);
    chk("badlen_no_write", wr_cnt - w0, 0);
    chk("badlen_no_hold", hold_cnt, 0);

    // Full memory, with a stray start mid-session
    clear_model();
    for (int i = 0; i < 600; i++) stream_bytes[i] = 8'((i * 7 + 3) ^ (i >> 2));
    w0 = wr_cnt; d0 = done_cnt;
    do_start(20'd150);
    send_bytes(0, 10, 1'b0);
    start = 1'b1; load_len = 20'd3;
    @(posedge clock); #1;
    start = 1'b0;
    send_bytes(10, 590, 1'b0);
    wait_done(d0);
    chk("full_writes", wr_cnt - w0, 150);
    chk("full_last_addr", last_addr, 149);
    exp_w = {stream_bytes[0], stream_bytes[1], stream_bytes[2], stream_bytes[3]};
    chk("full_word0", model[0], exp_w);
    exp_w = {stream_bytes[596], stream_bytes[597], stream_bytes[598], stream_bytes[599]};
    chk("full_word149", model[149], exp_w);
    chk("full_untouched150", model[150], BLANK);
    chk("full_done_cnt", done_cnt - d0, 1);
    chk("full_idle_addr", instr_addr, cpu_pc);

    // Abort partway through word 1 of a 3-word load
    clear_model();
    for (int i = 0; i < 12; i++) stream_bytes[i] = 8'h60 + 8'(i);
    w0 = wr_cnt; e0 = err_cnt; d0 = done_cnt;
    do_start(20'd3);
    send_bytes(0, 6, 1'b0);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    chk("abort_err_pulse", error, 1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("abort_idle_hold", cpu_hold, 0);
    chk("abort_idle_ready", bif.byte_ready, 0);
    chk("abort_writes", wr_cnt - w0, 1);
    chk("abort_word0", model[0], 32'h6061_6263);
    chk("abort_no_word1", model[1], BLANK);
    chk("abort_err_cnt", err_cnt - e0, 1);
    chk("abort_no_done", done_cnt - d0, 0);
    @(posedge clock); #1;

    // Reset mid-word, then reload from address 0
    clear_model();
    stream_bytes[0] = 8'hAA; stream_bytes[1] = 8'hBB;
    w0 = wr_cnt;
    do_start(20'd1);
    send_bytes(0, 2, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst2_ready", bif.byte_ready, 0);
    chk("rst2_hold", cpu_hold, 0);
    chk("rst2_wdata", mem_wdata, 0);
    chk("rst2_flags", {mem_we, done, error}, 0);
    chk("rst2_addr", instr_addr, cpu_pc);
    chk("rst2_no_write", wr_cnt - w0, 0);
    @(posedge clock); #1;
    stream_bytes[0] = 8'h11; stream_bytes[1] = 8'h22; stream_bytes[2] = 8'h33; stream_bytes[3] = 8'h44;
    d0 = done_cnt;
    do_start(20'd1);
    send_bytes(0, 4, 1'b0);
    wait_done(d0);
    chk("reload_writes", wr_cnt - w0, 1);
    chk("reload_addr", last_addr, 0);
    chk("reload_word0", model[0], 32'h1122_3344);
    chk("reload_done", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time controller that fills the processor's instruction memory from an external byte stream and arbitrates the memory's address port between itself and the fetch stage. It accepts bytes over a valid/ready handshake, packs four bytes into one 32-bit instruction word, writes words to consecutive addresses starting at 0, and holds the processor stalled for the whole session. It sits between the host/UART byte source, the processor's PC, and the instruction memory's address and write inputs.

## Interface
- MEM_SIZE, 150: number of instruction words; upper bound for load length.
- ADDR_WIDTH, 20: instruction address width.
- clock  in  1  single system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a load session; sampled only in IDLE.
- load_len  in  ADDR_WIDTH  number of words to load; sampled with start.
- abort  in  1  cancel an active session.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts byte this cycle.
- cpu_pc  in  ADDR_WIDTH  fetch address from processor.
- instr_addr  out  ADDR_WIDTH  address to instruction memory.
- mem_we  out  1  instruction-memory write strobe.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  stall processor (PC frozen, no fetch commit).
- done  out  1  one-cycle pulse: session completed.
- error  out  1  one-cycle pulse: bad length or abort.

## Operation
- States: IDLE, RECV, WRITE, DONE, ERR.
- IDLE: instr_addr = cpu_pc; cpu_hold=0; byte_ready=0. On start: load_len==0 or load_len>MEM_SIZE -> ERR; else latch len, wr_ptr=0, byte_cnt=0 -> RECV.
- RECV: byte_ready=1; cpu_hold=1; instr_addr=wr_ptr. Byte accepted when byte_valid && byte_ready. Big-endian packing: byte 0 -> bits 31:24, byte 3 -> bits 7:0. byte_cnt wraps 3->0; on acceptance of byte 3 -> WRITE.
- WRITE: exactly one cycle; mem_we=1, mem_wdata=packed word, instr_addr=wr_ptr, byte_ready=0. If wr_ptr==len-1 -> DONE; else wr_ptr+1 -> RECV.
- DONE: one cycle; done=1, cpu_hold=1, instr_addr=cpu_pc; -> IDLE.
- ERR: one cycle; error=1, cpu_hold=0, no write; -> IDLE.
- abort in RECV or WRITE: -> ERR next cycle; partial word discarded; in WRITE, the write of that cycle still occurs. abort in IDLE/DONE/ERR ignored.
- start outside IDLE ignored; load_len changes outside IDLE ignored.
- Words already written stay in memory after abort or reset; addresses beyond len untouched.
- wr_ptr and comparison use ADDR_WIDTH bits; len never exceeds MEM_SIZE, so no wrap.

## Timing
- Reset values: state IDLE, byte_ready=0, mem_we=0, mem_wdata=0, cpu_hold=0, done=0, error=0, wr_ptr=0, byte_cnt=0; instr_addr follows cpu_pc.
- All outputs registered except instr_addr (combinational mux of cpu_pc / wr_ptr by state) and byte_ready (decoded from state).
- start at cycle t -> RECV at t+1, byte_ready high at t+1.
- Minimum per word with byte_valid held high: 4 RECV cycles + 1 WRITE cycle = 5 cycles; N words: 5N cycles from first RECV to DONE, done at 5N+1 after start... precisely: DONE cycle is t+1+5N, IDLE (cpu_hold=0) at t+2+5N.
- byte_valid low stalls RECV indefinitely; no timeout.
- Bad length: start at t -> error=1 at t+1, IDLE at t+2; no mem_we ever.
- reset asserted in any state: next cycle IDLE with reset values; in-flight word dropped, no write.
- cpu_hold asserted from first RECV cycle through DONE inclusive; never glitches between words.

## Test plan
- Load len=2, bytes 0x20,0x00,0x00,0x42,0x30,0x1D,0x00,0x00 back-to-back -> mem_we at addr 0 with 0x20000042, addr 1 with 0x301D0000; done pulse 11 cycles after start; cpu_hold high 11 cycles.
- Same load with byte_valid toggling every other cycle -> identical writes, byte accepted only when valid&&ready, no duplicate bytes, byte_ready low in each WRITE cycle.
- start with load_len=0, then load_len=151 -> error pulse one cycle after each start, no mem_we, cpu_hold stays 0.
- Load len=150 full memory -> last write to addr 149, done pulse, instr_addr returns to cpu_pc; second start during session ignored.
- abort after 6 bytes of len=3 -> one write (addr 0), error pulse, no write of partial word 1, IDLE next.
- reset asserted mid-word in RECV -> all outputs at reset values next cycle, no mem_we, subsequent start loads from addr 0 correctly.
